// File: rtl/int_arbiter.sv
// Priority interrupt controller: synchronises raw request lines, latches rising edges as pending,
// and presents the lowest-index eligible source to the CPU over a valid/ack handshake with EOI nesting.
module int_arbiter #(
    parameter int              N_SRC    = 16,
    parameter int              ID_W     = (N_SRC > 1) ? $clog2(N_SRC) : 1,
    parameter logic [N_SRC-1:0] MASK_RST = '1
) (
    input  logic             clk,
    input  logic             RESETN,
    input  logic [N_SRC-1:0] int_raw,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    input  logic             ovf_clr,
    output logic             irq_valid,
    output logic [ID_W-1:0]  irq_id,
    input  logic             irq_ack,
    input  logic             irq_eoi,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] in_service,
    output logic [N_SRC-1:0] overflow
);

    typedef enum logic {IDLE, REQ} state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [N_SRC-1:0] sync1_q, sync2_q, prev_q;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] in_service_q, in_service_d;
    logic [N_SRC-1:0] overflow_q, overflow_d;
    logic [N_SRC-1:0] mask_q, mask_d;

    logic [N_SRC-1:0] rise, lowest_is, eligible, held_vec, ack_vec, eoi_vec;
    logic [ID_W-1:0]  winner;
    logic             ack_fire;

    // Isolating the lowest in-service bit gives both the EOI target and the
    // preemption threshold: (lowest - 1) is all ones below top, or all ones when idle.
    assign rise      = sync2_q & ~prev_q;
    assign lowest_is = in_service_q & (~in_service_q + N_SRC'(1));
    assign eligible  = pending_q & mask_q & (lowest_is - N_SRC'(1));
    assign held_vec  = N_SRC'(1) << id_q;
    assign ack_fire  = (state_q == REQ) && irq_ack;
    assign ack_vec   = ack_fire ? held_vec : '0;
    assign eoi_vec   = irq_eoi ? lowest_is : '0;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) winner = ID_W'(i);
        end
    end

    always_comb begin
        // EOI retires the old lowest bit before the accepted source is added.
        in_service_d = (in_service_q & ~eoi_vec) | ack_vec;
        pending_d    = (pending_q & ~ack_vec) | rise;
        overflow_d   = (ovf_clr ? '0 : overflow_q) | (rise & pending_q);
        mask_d       = mask_we ? mask_wdata : mask_q;
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    state_d = REQ;
                    id_d    = winner;
                end
            end
            REQ: begin
                if (ack_fire || !(|(eligible & held_vec))) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        irq_valid  = (state_q == REQ);
        irq_id     = id_q;
        pending    = pending_q;
        in_service = in_service_q;
        overflow   = overflow_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge RESETN) begin
        if (!RESETN) begin
            state_q      <= IDLE;
            id_q         <= '0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            prev_q       <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
            overflow_q   <= '0;
            mask_q       <= MASK_RST;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            sync1_q      <= int_raw;
            sync2_q      <= sync1_q;
            prev_q       <= sync2_q;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            overflow_q   <= overflow_d;
            mask_q       <= mask_d;
        end
    end

endmodule

// File: tb/tb_int_arbiter.sv
// Directed bench for int_arbiter: edge latency, priority, nesting, masking,
// overflow/ack race and asynchronous reset, with hand-computed expectations.
module tb_int_arbiter;

    localparam int N_SRC = 16;
    localparam int ID_W  = 4;

    logic             clk = 1'b0;
    logic             RESETN;
    logic [N_SRC-1:0] int_raw;
    logic             mask_we;
    logic [N_SRC-1:0] mask_wdata;
    logic             ovf_clr;
    logic             irq_valid;
    logic [ID_W-1:0]  irq_id;
    logic             irq_ack;
    logic             irq_eoi;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] in_service;
    logic [N_SRC-1:0] overflow;

    int n_checks = 0;
    int n_pass   = 0;

    int_arbiter #(.N_SRC(N_SRC)) dut (
        .clk        (clk),
        .RESETN     (RESETN),
        .int_raw    (int_raw),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .ovf_clr    (ovf_clr),
        .irq_valid  (irq_valid),
        .irq_id     (irq_id),
        .irq_ack    (irq_ack),
        .irq_eoi    (irq_eoi),
        .pending    (pending),
        .in_service (in_service),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle raw pulse, then wait until it lands in pending (3 rising edges).
    task automatic raise(input logic [N_SRC-1:0] bits);
        int_raw = int_raw | bits;
        step();
        int_raw = int_raw & ~bits;
        step(2);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20 && !irq_valid; i++) step();
        check(tag, 32'(irq_valid), 32'd1);
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
    endtask

    task automatic eoi();
        irq_eoi = 1'b1;
        step();
        irq_eoi = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        RESETN = 1'b0; int_raw = '0; mask_we = 1'b0; mask_wdata = '0;
        ovf_clr = 1'b0; irq_ack = 1'b0; irq_eoi = 1'b0;
        step(3);
        check("rst_valid", 32'(irq_valid), 32'd0);
        check("rst_pending", 32'(pending), 32'h0);
        RESETN = 1'b1;
        step();

        // Single edge on bit 10: exact latency
        int_raw[10] = 1'b1;
        step(3);
        check("lat_pending", 32'(pending), 32'h0400);
        check("lat_valid_early", 32'(irq_valid), 32'd0);
        step();
        check("lat_valid", 32'(irq_valid), 32'd1);
        check("lat_id", 32'(irq_id), 32'd10);
        step();
        int_raw[10] = 1'b0;
        ack();
        check("ack_pending", 32'(pending), 32'h0);
        check("ack_in_service", 32'(in_service), 32'h0400);
        check("ack_valid", 32'(irq_valid), 32'd0);
        eoi();
        check("eoi_in_service", 32'(in_service), 32'h0);

        // Priority: bits 7 and 2 together
        raise(16'h0084);
        check("prio_pending", 32'(pending), 32'h0084);
        step();
        check("prio_id_first", 32'(irq_id), 32'd2);
        ack();
        check("prio_in_service", 32'(in_service), 32'h0004);
        step(3);
        check("prio_blocked", 32'(irq_valid), 32'd0);
        eoi();
        step();
        check("prio_valid_second", 32'(irq_valid), 32'd1);
        check("prio_id_second", 32'(irq_id), 32'd7);
        ack();
        eoi();

        // Nesting: bit 1 preempts bit 5
        raise(16'h0020);
        wait_valid("nest_valid5");
        ack();
        check("nest_is5", 32'(in_service), 32'h0020);
        raise(16'h0002);
        wait_valid("nest_valid1");
        check("nest_id1", 32'(irq_id), 32'd1);
        ack();
        check("nest_is22", 32'(in_service), 32'h0022);
        eoi();
        check("nest_eoi1", 32'(in_service), 32'h0020);
        eoi();
        check("nest_eoi2", 32'(in_service), 32'h0000);
        eoi();
        check("nest_eoi_empty", 32'(in_service), 32'h0000);

        // Mask withdraw and re-present
        raise(16'h0008);
        wait_valid("mask_valid");
        check("mask_id", 32'(irq_id), 32'd3);
        mask_we = 1'b1; mask_wdata = 16'hFFF7;
        step();
        mask_we = 1'b0;
        step();
        check("mask_withdrawn", 32'(irq_valid), 32'd0);
        check("mask_pending_kept", 32'(pending), 32'h0008);
        mask_we = 1'b1; mask_wdata = 16'hFFFF;
        step();
        mask_we = 1'b0;
        step();
        check("unmask_valid", 32'(irq_valid), 32'd1);
        check("unmask_id", 32'(irq_id), 32'd3);
        ack();
        eoi();

        // Overflow and set-wins race on bit 4
        raise(16'h0010);
        wait_valid("ovf_valid");
        check("ovf_none", 32'(overflow), 32'h0);
        raise(16'h0010);
        check("ovf_set", 32'(overflow), 32'h0010);
        int_raw[4] = 1'b1;
        step();
        int_raw[4] = 1'b0;
        step();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("race_pending", 32'(pending), 32'h0010);
        check("race_in_service", 32'(in_service), 32'h0010);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 32'h0);
        step(2);
        check("self_blocked", 32'(irq_valid), 32'd0);
        eoi();
        wait_valid("race_revalid");
        check("race_id", 32'(irq_id), 32'd4);
        ack();
        eoi();
        check("race_clean", 32'(pending | in_service), 32'h0);

        // Async reset while a nested request is presented
        mask_we = 1'b1; mask_wdata = 16'hFEFF;
        step();
        mask_we = 1'b0;
        raise(16'h0040);
        wait_valid("rst_valid6");
        ack();
        raise(16'h0001);
        wait_valid("rst_valid0");
        check("rst_pre_is", 32'(in_service), 32'h0040);
        #2 RESETN = 1'b0;
        #1;
        check("arst_valid", 32'(irq_valid), 32'd0);
        check("arst_id", 32'(irq_id), 32'd0);
        check("arst_in_service", 32'(in_service), 32'h0);
        check("arst_pending", 32'(pending), 32'h0);
        check("arst_overflow", 32'(overflow), 32'h0);
        step();
        RESETN = 1'b1;
        raise(16'h0100);
        wait_valid("arst_mask_valid");
        check("arst_mask_id", 32'(irq_id), 32'd8);
        ack();
        eoi();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
